// File: rtl/icetap_jtag_master_pkg.sv
// Shared command codes and FSM state encoding for the icetap JTAG master.
package icetap_jtag_master_pkg;

    localparam logic [1:0] JTAG_MASTER_CMD_RESET = 2'd0;
    localparam logic [1:0] JTAG_MASTER_CMD_IR    = 2'd1;
    localparam logic [1:0] JTAG_MASTER_CMD_DR    = 2'd2;

    localparam int TLR_TICKS = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TLR,
        ST_RTI,
        ST_SEL_DR,
        ST_SEL_IR,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_DONE,
        ST_RESP
    } jtag_state_e;

endpackage

// File: rtl/icetap_tck_gen.sv
// TCK divider: low phase then high phase of TCK_DIV clk cycles each while enabled.
module icetap_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_,
    input  logic en,
    output logic tck,
    output logic tick_fall,
    output logic tick_rise
);

    localparam int CNT_W = $clog2(2 * TCK_DIV);
    localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] FALL_AT = CNT_W'(2 * TCK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_rise = en && (cnt == RISE_AT);
    assign tick_fall = en && (cnt == FALL_AT);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (tick_fall) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (tick_rise)
                tck <= 1'b1;
        end
    end

endmodule

// File: rtl/icetap_jtag_master.sv
// Host-side JTAG initiator: RESET / IR / DR commands to TCK/TMS/TDI with TDO capture.
// Optional TDO capture path: ICETAP_JTAG_MASTER_TDO_CAPTURE_EN (undefined = write-only master).
module icetap_jtag_master
    import icetap_jtag_master_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int TCK_DIV = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    jtag_state_e        state;
    logic [2:0]         sub_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   nxt_idx;
    logic [IDX_W-1:0]   last_q;
    logic [1:0]         type_q;
    logic [MAX_LEN-1:0] data_q;
    logic               tap_known;
    logic               tck_en;
    logic               tick_fall;
    logic               tick_rise;
    logic               cmd_accept;

    // Zero-length scans shift one bit; oversize scans clamp to MAX_LEN.
    function automatic logic [IDX_W-1:0] last_index(input logic [LEN_W-1:0] len);
        if (len == '0)
            return '0;
        else if (len > LEN_W'(MAX_LEN))
            return IDX_W'(MAX_LEN - 1);
        else
            return IDX_W'(len - 1'b1);
    endfunction

    assign cmd_accept = cmd_valid && cmd_ready;
    assign busy       = !cmd_ready;
    assign nxt_idx    = bit_idx + 1'b1;

    icetap_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk       (clk),
        .reset_    (reset_),
        .en        (tck_en),
        .tck       (jtag_tck),
        .tick_fall (tick_fall),
        .tick_rise (tick_rise)
    );

    always_ff @(posedge clk) begin
        if (cmd_accept)
            data_q <= cmd_data;
    end

    // Each state is one TCK tick; TMS/TDI for the next tick are set on tick_fall.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= ST_IDLE;
            sub_cnt   <= '0;
            bit_idx   <= '0;
            last_q    <= '0;
            type_q    <= JTAG_MASTER_CMD_RESET;
            tap_known <= 1'b0;
            tck_en    <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        cmd_ready <= 1'b0;
                        type_q    <= cmd_type;
                        last_q    <= last_index(cmd_len);
                        sub_cnt   <= '0;
                        case (cmd_type)
                            JTAG_MASTER_CMD_RESET: begin
                                state    <= ST_TLR;
                                jtag_tms <= 1'b1;
                                tck_en   <= 1'b1;
                            end
                            JTAG_MASTER_CMD_IR, JTAG_MASTER_CMD_DR: begin
                                state    <= tap_known ? ST_SEL_DR : ST_TLR;
                                jtag_tms <= 1'b1;
                                tck_en   <= 1'b1;
                            end
                            default: state <= ST_RESP;
                        endcase
                    end
                end
                ST_RESP: begin
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    if (tick_fall) begin
                        case (state)
                            ST_TLR: begin
                                if (sub_cnt == 3'(TLR_TICKS - 1)) begin
                                    state    <= ST_RTI;
                                    jtag_tms <= 1'b0;
                                end else begin
                                    sub_cnt <= sub_cnt + 1'b1;
                                end
                            end
                            ST_RTI: begin
                                tap_known <= 1'b1;
                                if (type_q == JTAG_MASTER_CMD_RESET) begin
                                    state  <= ST_RESP;
                                    tck_en <= 1'b0;
                                end else begin
                                    state    <= ST_SEL_DR;
                                    jtag_tms <= 1'b1;
                                end
                            end
                            ST_SEL_DR: begin
                                sub_cnt <= '0;
                                if (type_q == JTAG_MASTER_CMD_IR) begin
                                    state    <= ST_SEL_IR;
                                    jtag_tms <= 1'b1;
                                end else begin
                                    state    <= ST_CAPTURE;
                                    jtag_tms <= 1'b0;
                                end
                            end
                            ST_SEL_IR: begin
                                sub_cnt  <= '0;
                                state    <= ST_CAPTURE;
                                jtag_tms <= 1'b0;
                            end
                            // Two TMS=0 ticks: enter Capture, then Capture -> Shift.
                            ST_CAPTURE: begin
                                if (sub_cnt == '0) begin
                                    sub_cnt <= 3'd1;
                                end else begin
                                    state    <= ST_SHIFT;
                                    bit_idx  <= '0;
                                    jtag_tdi <= data_q[0];
                                    jtag_tms <= (last_q == '0);
                                end
                            end
                            ST_SHIFT: begin
                                if (bit_idx == last_q) begin
                                    state    <= ST_UPDATE;
                                    jtag_tms <= 1'b1;
                                    jtag_tdi <= 1'b0;
                                end else begin
                                    bit_idx  <= nxt_idx;
                                    jtag_tdi <= data_q[nxt_idx];
                                    jtag_tms <= (nxt_idx == last_q);
                                end
                            end
                            ST_UPDATE: begin
                                state    <= ST_DONE;
                                jtag_tms <= 1'b0;
                            end
                            ST_DONE: begin
                                state  <= ST_RESP;
                                tck_en <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef ICETAP_JTAG_MASTER_TDO_CAPTURE_EN
    logic [MAX_LEN-1:0] cap_q;
    logic [MAX_LEN-1:0] rsp_q;

    always_ff @(posedge clk) begin
        if (cmd_accept)
            cap_q <= '0;
        else if (state == ST_SHIFT && tick_rise)
            cap_q[bit_idx] <= jtag_tdo;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            rsp_q <= '0;
        else if (state == ST_RESP)
            rsp_q <= cap_q;
    end

    assign rsp_data = rsp_q;
`else
    logic unused_tdo;
    assign unused_tdo = jtag_tdo | tick_rise;
    assign rsp_data   = '0;
`endif

endmodule

// File: tb/tb_icetap_jtag_master.sv
// Directed bench for icetap_jtag_master against a behavioural IEEE 1149.1 TAP model.
module tb_icetap_jtag_master;

    localparam int MAX_LEN = 32;
    localparam int TCK_DIV = 2;
    localparam int LEN_W   = 6;
    localparam logic [3:0]  IR_CAP = 4'b0001;
    localparam logic [31:0] CAP_DR = 32'h1234_5679;

    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
    localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    logic               clk = 1'b0;
    logic               reset_;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_type;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               jtag_tck;
    logic               jtag_tms;
    logic               jtag_tdi;
    logic               jtag_tdo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    icetap_jtag_master #(
        .MAX_LEN (MAX_LEN),
        .TCK_DIV (TCK_DIV),
        .LEN_W   (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .jtag_tck  (jtag_tck),
        .jtag_tms  (jtag_tms),
        .jtag_tdi  (jtag_tdi),
        .jtag_tdo  (jtag_tdo)
    );

    always #5 clk = ~clk;

    // TAP model: starts mid Shift-DR so the automatic TLR prefix matters.
    int          tap_st = SHDR;
    logic [3:0]  ir_sr  = 4'h0;
    logic [3:0]  ir_reg = 4'h0;
    logic [31:0] dr_sr  = 32'h0;
    logic [31:0] dr_reg = 32'h0;

    assign jtag_tdo = (tap_st == SHIR) ? ir_sr[0] : dr_sr[0];

    always @(posedge jtag_tck) begin
        case (tap_st)
            CDR:  dr_sr  <= CAP_DR;
            SHDR: dr_sr  <= {jtag_tdi, dr_sr[31:1]};
            UDR:  dr_reg <= dr_sr;
            CIR:  ir_sr  <= IR_CAP;
            SHIR: ir_sr  <= {jtag_tdi, ir_sr[3:1]};
            UIR:  ir_reg <= ir_sr;
            default: ;
        endcase
        case (tap_st)
            TLR:  tap_st <= jtag_tms ? TLR  : RTI;
            RTI:  tap_st <= jtag_tms ? SDR  : RTI;
            SDR:  tap_st <= jtag_tms ? SIR  : CDR;
            CDR:  tap_st <= jtag_tms ? E1DR : SHDR;
            SHDR: tap_st <= jtag_tms ? E1DR : SHDR;
            E1DR: tap_st <= jtag_tms ? UDR  : PDR;
            PDR:  tap_st <= jtag_tms ? E2DR : PDR;
            E2DR: tap_st <= jtag_tms ? UDR  : SHDR;
            UDR:  tap_st <= jtag_tms ? SDR  : RTI;
            SIR:  tap_st <= jtag_tms ? TLR  : CIR;
            CIR:  tap_st <= jtag_tms ? E1IR : SHIR;
            SHIR: tap_st <= jtag_tms ? E1IR : SHIR;
            E1IR: tap_st <= jtag_tms ? UIR  : PIR;
            PIR:  tap_st <= jtag_tms ? E2IR : PIR;
            E2IR: tap_st <= jtag_tms ? UIR  : SHIR;
            default: tap_st <= jtag_tms ? SDR : RTI;
        endcase
    end

    int          tck_rises   = 0;
    int          rsp_pulses  = 0;
    logic [63:0] tms_trace   = '0;
    logic [63:0] tdi_trace   = '0;

    always @(posedge jtag_tck) begin
        tck_rises <= tck_rises + 1;
        tms_trace <= {tms_trace[62:0], jtag_tms};
        tdi_trace <= {tdi_trace[62:0], jtag_tdi};
    end

    always @(negedge clk) begin
        if (rsp_valid)
            rsp_pulses <= rsp_pulses + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input int len);
        if (len == 0) return 1;
        if (len > MAX_LEN) return MAX_LEN;
        return len;
    endfunction

    function automatic logic [31:0] exp_capture(input logic [1:0] t, input int len);
        logic [31:0] m;
        logic [31:0] v;
        m = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
        v = '0;
        if (t == 2'd1) v = 32'(IR_CAP) & m;
        else if (t == 2'd2) v = CAP_DR & m;
`ifndef ICETAP_JTAG_MASTER_TDO_CAPTURE_EN
        v = '0;
`endif
        return v;
    endfunction

    // Expected TMS/TDI per TCK rise, oldest tick in the highest bit.
    function automatic void build_exp(input logic [1:0] t, input bit prefix, input int len,
                                      input logic [31:0] d, output logic [63:0] tms,
                                      output logic [63:0] tdi, output int ticks);
        tms = '0;
        tdi = '0;
        ticks = 0;
        if (t == 2'd3) return;
        if (prefix || t == 2'd0) begin
            for (int i = 0; i < 6; i++) begin
                tms = {tms[62:0], (i < 5)};
                tdi = {tdi[62:0], 1'b0};
                ticks++;
            end
        end
        if (t == 2'd0) return;
        tms = {tms[62:0], 1'b1}; tdi = {tdi[62:0], 1'b0}; ticks++;
        if (t == 2'd1) begin
            tms = {tms[62:0], 1'b1}; tdi = {tdi[62:0], 1'b0}; ticks++;
        end
        for (int i = 0; i < 2; i++) begin
            tms = {tms[62:0], 1'b0}; tdi = {tdi[62:0], 1'b0}; ticks++;
        end
        for (int i = 0; i < len; i++) begin
            tms = {tms[62:0], (i == len - 1)}; tdi = {tdi[62:0], d[i]}; ticks++;
        end
        tms = {tms[62:0], 1'b1}; tdi = {tdi[62:0], 1'b0}; ticks++;
        tms = {tms[62:0], 1'b0}; tdi = {tdi[62:0], 1'b0}; ticks++;
    endfunction

    task automatic run_cmd(input string tag, input logic [1:0] t, input logic [LEN_W-1:0] len,
                           input logic [31:0] d, input bit prefix, input int hold);
        logic [63:0] etms, etdi, mask;
        logic [31:0] erx;
        int eticks, n, start, p0, el;
        el = eff_len(int'(len));
        build_exp(t, prefix, el, d, etms, etdi, eticks);
        exp_q.push_back(exp_capture(t, el));
        start = tck_rises;
        p0    = rsp_pulses;
        @(negedge clk);
        chk({tag, "_ready_before"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_len   = len;
        cmd_data  = d;
        @(posedge clk);
        #1;
        chk({tag, "_busy_after_accept"}, busy, 1'b1);
        if (hold == 0) cmd_valid = 1'b0;
        else begin
            cmd_data = ~d;
            cmd_type = 2'd2;
        end
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (n >= hold) cmd_valid = 1'b0;
            if (rsp_valid) break;
        end
        cmd_valid = 1'b0;
        chk({tag, "_latency"}, n, 2 * TCK_DIV * eticks + 1);
        if (rsp_valid) begin
            erx = exp_q.pop_front();
            chk({tag, "_rsp_data"}, rsp_data, erx);
            chk({tag, "_ready_with_rsp"}, cmd_ready, 1'b1);
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_rsp_stable"}, rsp_data, exp_capture(t, el));
        chk({tag, "_tck_ticks"}, tck_rises - start, eticks);
        chk({tag, "_rsp_pulses"}, rsp_pulses - p0, 1);
        if (eticks > 0) begin
            mask = (64'd1 << eticks) - 64'd1;
            chk({tag, "_tms_seq"}, tms_trace & mask, etms);
            chk({tag, "_tdi_seq"}, tdi_trace & mask, etdi);
            chk({tag, "_tms_rest"}, jtag_tms, 1'b0);
        end
    endtask

    initial begin
        int start, p0, guard;
        reset_    = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 2'd0;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tck", jtag_tck, 1'b0);
        chk("rst_tms", jtag_tms, 1'b1);
        chk("rst_tdi", jtag_tdi, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_tap_known", dut.tap_known, 1'b0);
        @(negedge clk);
        reset_ = 1'b1;

        run_cmd("dr_prefix", 2'd2, 6'd32, 32'hDEAD_BEEF, 1'b1, 0);
        chk("dr_prefix_model_dr", dr_reg, 32'hDEAD_BEEF);
        chk("dr_prefix_tap_known", dut.tap_known, 1'b1);

        run_cmd("reset_cmd", 2'd0, 6'd0, 32'h0, 1'b1, 0);
        chk("reset_cmd_model_rti", tap_st, RTI);

        run_cmd("ir4", 2'd1, 6'd4, 32'hA, 1'b0, 0);
        chk("ir4_model_ir", ir_reg, 4'hA);

        run_cmd("len0", 2'd2, 6'd0, 32'h1, 1'b0, 0);
        run_cmd("len_over", 2'd2, 6'(MAX_LEN + 5), 32'h0F0F_1234, 1'b0, 0);
        chk("len_over_model_dr", dr_reg, 32'h0F0F_1234);
        run_cmd("dr8", 2'd2, 6'd8, 32'hA5, 1'b0, 0);
        chk("dr8_model_dr", dr_reg, {8'hA5, CAP_DR[31:8]});

        run_cmd("undef", 2'd3, 6'd8, 32'hFF, 1'b0, 0);

        run_cmd("busy_hold", 2'd2, 6'd8, 32'h3C, 1'b0, 10);
        chk("busy_hold_model_dr", dr_reg, {8'h3C, CAP_DR[31:8]});

        // Mid-scan reset: tick 7 is shift bit 3 of a DR scan with the TAP known.
        start = tck_rises;
        p0    = rsp_pulses;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = 2'd2;
        cmd_len   = 6'd8;
        cmd_data  = 32'h77;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        guard = 0;
        while ((tck_rises - start) < 7 && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("midrst_reached_bit3", tck_rises - start, 7);
        reset_ = 1'b0;
        #1;
        chk("midrst_tck", jtag_tck, 1'b0);
        chk("midrst_tms", jtag_tms, 1'b1);
        chk("midrst_tdi", jtag_tdi, 1'b0);
        chk("midrst_ready", cmd_ready, 1'b1);
        chk("midrst_tap_known", dut.tap_known, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_ = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("midrst_no_rsp", rsp_pulses - p0, 0);

        run_cmd("after_midrst", 2'd2, 6'd8, 32'h5A, 1'b1, 0);
        chk("after_midrst_model_dr", dr_reg, {8'h5A, CAP_DR[31:8]});

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
